// File: rtl/cpu_pkg.sv
// Shared CPU package: arbiter state encoding and memory-owner codes.
// Contents:
//   arb_state_t : IDLE / ACCESS / RESP states of the memory arbiter FSM
//   owner_t     : which requester owns the current access (IF or D)
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Handshake and memory bus bundle around mem_arbiter.
// Signals:
//   if_req/if_addr/if_ack          : instruction-fetch read port
//   d_req/d_we/d_addr/d_wdata/d_ack: load/store port
//   rdata                          : shared read-data return (valid with an ack)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : single-port memory macro side
// Modports:
//   slave  : the arbiter's view
//   master : the CPU requesters plus memory macro (the arbiter's environment)
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_ack, d_ack, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_ack, d_ack, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational 2-way round-robin picker.
// Ports:
//   req_if, req_d     : raw requests
//   last_grant        : owner of the most recent grant (loses a tie)
//   exclude_valid     : when set, exclude_owner may not be granted
//   exclude_owner     : requester to mask (the owner finishing its access)
//   grant_valid       : some eligible request is present
//   grant_owner       : the chosen requester
module mem_arb_pick
   import cpu_pkg::*;
(
   input  logic   req_if,
   input  logic   req_d,
   input  owner_t last_grant,
   input  logic   exclude_valid,
   input  owner_t exclude_owner,
   output logic   grant_valid,
   output owner_t grant_owner
);
   logic cand_if;
   logic cand_d;

   always_comb begin
      cand_if     = req_if && !(exclude_valid && (exclude_owner == OWN_IF));
      cand_d      = req_d  && !(exclude_valid && (exclude_owner == OWN_D));
      grant_valid = cand_if || cand_d;
      grant_owner = OWN_IF;
      if (cand_if && cand_d)
         grant_owner = (last_grant == OWN_IF) ? OWN_D : OWN_IF;
      else if (cand_d)
         grant_owner = OWN_D;
   end
endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between the CPU's
// instruction-fetch path and its load/store path.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : mem_arbiter_if.slave (requester handshakes + memory macro)
//   busy     : high whenever an access is in flight (state != IDLE)
// Flow: IDLE -> ACCESS (mem_en with latched request) -> RESP (owner ack,
// rdata = mem_rdata). From RESP the other requester is granted directly.
module mem_arbiter
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus,
   output logic          busy
);
   arb_state_t        state, state_n;
   owner_t            owner_q;
   owner_t            last_grant;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic   grant_valid;
   owner_t grant_owner;
   logic   take_grant;

   // In RESP the owner's req is still high; masking it lets only the
   // other requester chain straight into ACCESS.
   mem_arb_pick u_pick (
      .req_if        (bus.if_req),
      .req_d         (bus.d_req),
      .last_grant    (last_grant),
      .exclude_valid (state == RESP),
      .exclude_owner (owner_q),
      .grant_valid   (grant_valid),
      .grant_owner   (grant_owner)
   );

   always_comb begin
      state_n    = state;
      take_grant = 1'b0;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               state_n    = ACCESS;
               take_grant = 1'b1;
            end
         end
         ACCESS: state_n = RESP;
         RESP: begin
            if (grant_valid) begin
               state_n    = ACCESS;
               take_grant = 1'b1;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner_q    <= OWN_IF;
         last_grant <= OWN_D;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state <= state_n;
         if (take_grant) begin
            owner_q    <= grant_owner;
            last_grant <= grant_owner;
            if (grant_owner == OWN_D) begin
               we_q    <= bus.d_we;
               addr_q  <= bus.d_addr;
               wdata_q <= bus.d_wdata;
            end else begin
               we_q    <= 1'b0;
               addr_q  <= bus.if_addr;
               wdata_q <= '0;
            end
         end
      end
   end

   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.if_ack    = 1'b0;
      bus.d_ack     = 1'b0;
      bus.rdata     = '0;
      busy          = (state != IDLE);
      if (state == ACCESS) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = we_q;
         bus.mem_addr  = addr_q;
         bus.mem_wdata = wdata_q;
      end else if (state == RESP) begin
         bus.if_ack = (owner_q == OWN_IF);
         bus.d_ack  = (owner_q == OWN_D);
         bus.rdata  = bus.mem_rdata;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle vector table plus a
// sustained-contention sequence. Includes a behavioural memory macro.
module tb_mem_arbiter;
   localparam int unsigned AW = 8;
   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   logic rst;
   logic busy;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   // Memory macro: write on mem_en&mem_we, registered read otherwise.
   logic [DW-1:0] mem [256];
   logic          pl_en;
   logic [AW-1:0] pl_addr;
   logic [DW-1:0] pl_data;

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
   end

   int unsigned errors = 0;
   int unsigned checks = 0;

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
      end
   endtask

   typedef struct {
      logic          rst;
      logic          if_req;
      logic [AW-1:0] if_addr;
      logic          d_req;
      logic          d_we;
      logic [AW-1:0] d_addr;
      logic [DW-1:0] d_wdata;
      logic          e_busy;
      logic          e_en;
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      logic          e_if_ack;
      logic          e_d_ack;
      logic [DW-1:0] e_rdata;
   } vec_t;

   vec_t vq[$];

   initial begin
      rst = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.mem_rdata = '0;
      pl_en = 1'b1; pl_addr = 8'h10; pl_data = 32'hDEADBEEF;
      @(posedge clk); #1;
      pl_en = 1'b0;

      //         rst ifr ifa    dr dwe da     dwdata        busy en we addr   wdata         ifa da rdata
      vq.push_back('{1, 0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0, 32'h0});        // reset
      vq.push_back('{0, 1, 8'h10, 0, 0, 8'h00, 32'h0,        1, 1, 0, 8'h10, 32'h0,        0, 0, 32'h0});        // fetch ACCESS
      vq.push_back('{0, 1, 8'h10, 0, 0, 8'h00, 32'h0,        1, 0, 0, 8'h00, 32'h0,        1, 0, 32'hDEADBEEF}); // fetch RESP
      vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0, 32'h0});
      vq.push_back('{0, 0, 8'h00, 1, 1, 8'h20, 32'h12345678, 1, 1, 1, 8'h20, 32'h12345678, 0, 0, 32'h0});        // store ACCESS
      vq.push_back('{0, 0, 8'h00, 1, 1, 8'h20, 32'h12345678, 1, 0, 0, 8'h00, 32'h0,        0, 1, 32'hDEADBEEF}); // store RESP, stale rdata
      vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0, 32'h0});
      vq.push_back('{0, 0, 8'h00, 1, 0, 8'h20, 32'h0,        1, 1, 0, 8'h20, 32'h0,        0, 0, 32'h0});        // load ACCESS
      vq.push_back('{0, 0, 8'h00, 1, 0, 8'h20, 32'h0,        1, 0, 0, 8'h00, 32'h0,        0, 1, 32'h12345678}); // load RESP
      vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0, 32'h0});
      vq.push_back('{1, 0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0, 32'h0});        // reset
      vq.push_back('{0, 1, 8'h10, 1, 0, 8'h20, 32'h0,        1, 1, 0, 8'h10, 32'h0,        0, 0, 32'h0});        // conflict: IF wins
      vq.push_back('{0, 1, 8'h10, 1, 0, 8'h20, 32'h0,        1, 0, 0, 8'h00, 32'h0,        1, 0, 32'hDEADBEEF});
      vq.push_back('{0, 0, 8'h10, 1, 0, 8'h20, 32'h0,        1, 1, 0, 8'h20, 32'h0,        0, 0, 32'h0});        // D chained, no IDLE
      vq.push_back('{0, 0, 8'h10, 1, 0, 8'h20, 32'h0,        1, 0, 0, 8'h00, 32'h0,        0, 1, 32'h12345678});
      vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0, 32'h0});
      vq.push_back('{0, 0, 8'h00, 1, 0, 8'h10, 32'h0,        1, 1, 0, 8'h10, 32'h0,        0, 0, 32'h0});        // 1-cycle d_req
      vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        1, 0, 0, 8'h00, 32'h0,        0, 1, 32'hDEADBEEF});
      vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0, 32'h0});
      vq.push_back('{0, 1, 8'h20, 0, 0, 8'h00, 32'h0,        1, 1, 0, 8'h20, 32'h0,        0, 0, 32'h0});        // fetch ACCESS
      vq.push_back('{1, 1, 8'h20, 0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0, 32'h0});        // reset in ACCESS
      vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0, 32'h0});        // no stray ack
      vq.push_back('{0, 1, 8'h20, 0, 0, 8'h00, 32'h0,        1, 1, 0, 8'h20, 32'h0,        0, 0, 32'h0});
      vq.push_back('{0, 1, 8'h20, 0, 0, 8'h00, 32'h0,        1, 0, 0, 8'h00, 32'h0,        1, 0, 32'h12345678});
      vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0, 32'h0});
      vq.push_back('{0, 0, 8'h00, 1, 1, 8'h30, 32'hA5A5A5A5, 1, 1, 1, 8'h30, 32'hA5A5A5A5, 0, 0, 32'h0});        // store ACCESS
      vq.push_back('{1, 0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0, 32'h0});        // reset: store committed
      vq.push_back('{0, 0, 8'h00, 1, 0, 8'h30, 32'h0,        1, 1, 0, 8'h30, 32'h0,        0, 0, 32'h0});
      vq.push_back('{0, 0, 8'h00, 1, 0, 8'h30, 32'h0,        1, 0, 0, 8'h00, 32'h0,        0, 1, 32'hA5A5A5A5});
      vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 0, 0, 8'h00, 32'h0,        0, 0, 32'h0});

      foreach (vq[i]) begin
         rst         = vq[i].rst;
         bus.if_req  = vq[i].if_req;
         bus.if_addr = vq[i].if_addr;
         bus.d_req   = vq[i].d_req;
         bus.d_we    = vq[i].d_we;
         bus.d_addr  = vq[i].d_addr;
         bus.d_wdata = vq[i].d_wdata;
         @(posedge clk); #1;
         check("busy",      i, 32'(busy),          32'(vq[i].e_busy));
         check("mem_en",    i, 32'(bus.mem_en),    32'(vq[i].e_en));
         check("mem_we",    i, 32'(bus.mem_we),    32'(vq[i].e_we));
         check("mem_addr",  i, 32'(bus.mem_addr),  32'(vq[i].e_addr));
         check("mem_wdata", i, bus.mem_wdata,      vq[i].e_wdata);
         check("if_ack",    i, 32'(bus.if_ack),    32'(vq[i].e_if_ack));
         check("d_ack",     i, 32'(bus.d_ack),     32'(vq[i].e_d_ack));
         check("rdata",     i, bus.rdata,          vq[i].e_rdata);
      end

      // Sustained contention: last grant was D, so IF leads; 10 accesses
      // alternate IF, D, ... in ACCESS/RESP pairs with no IDLE gap.
      begin
         logic prev_ack;
         logic own_d;
         prev_ack = 1'b0;
         bus.if_req = 1'b1; bus.if_addr = 8'h10;
         bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h20; bus.d_wdata = '0;
         for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            own_d = (((c - 1) / 2) % 2) == 1;
            check("sc.mem_en", c, 32'(bus.mem_en), 32'(c % 2));
            check("sc.busy",   c, 32'(busy), 32'd1);
            if (c % 2 == 1) begin
               check("sc.mem_addr", c, 32'(bus.mem_addr), own_d ? 32'h20 : 32'h10);
            end else begin
               check("sc.if_ack", c, 32'(bus.if_ack), 32'(!own_d));
               check("sc.d_ack",  c, 32'(bus.d_ack),  32'(own_d));
               check("sc.rdata",  c, bus.rdata, own_d ? 32'h12345678 : 32'hDEADBEEF);
            end
            check("sc.ack_both", c, 32'(bus.if_ack && bus.d_ack), 32'd0);
            check("sc.ack_long", c, 32'(prev_ack && (bus.if_ack || bus.d_ack)), 32'd0);
            prev_ack = bus.if_ack || bus.d_ack;
         end
         bus.if_req = 1'b0; bus.d_req = 1'b0;
         @(posedge clk); #1;
         check("sc.idle_busy", 21, 32'(busy), 32'd0);
         check("sc.idle_en",   21, 32'(bus.mem_en), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
